// File: rtl/spi_reg_file.sv
// spi_reg_file: register bank behind the SPI slave.
// Holds the control registers, scratch space, synchronized status inputs and a
// sticky event register with a masked interrupt. It also keeps a write counter.
// Optional link-loss watchdog, enabled by defining SPI_REG_WDOG_EN.
//
// Ports:
//   clock, reset_n      main clock, asynchronous active-low reset
//   address[5:0]        register address from the SPI slave
//   write_en, wr_data   one-cycle write strobe and its data
//   read_en             one-cycle read strobe
//   rd_data[7:0]        registered read data, held until the next read
//   status_in[63:0]     asynchronous status bits, byte k at 0x30+k
//   event_in[7:0]       single-cycle event pulses (clock domain)
//   ctrl_out[127:0]     control regs 0x00-0x0F, byte k = bits 8k+7:8k
//   write_strobe[15:0]  one-cycle pulse per written control register
//   irq                 |(event_reg & event_mask), registered
//   wdog_timeout        high while the link watchdog is expired
module spi_reg_file #(
    parameter logic [7:0]  ID_VALUE    = 8'hB5,
    parameter logic [23:0] WDOG_CYCLES = 24'd5_000_000
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic [5:0]   address,
    input  logic         write_en,
    input  logic [7:0]   wr_data,
    input  logic         read_en,
    output logic [7:0]   rd_data,
    input  logic [63:0]  status_in,
    input  logic [7:0]   event_in,
    output logic [127:0] ctrl_out,
    output logic [15:0]  write_strobe,
    output logic         irq,
    output logic         wdog_timeout
);

    localparam int unsigned NUM_SCRATCH = 32;

    logic [7:0]  scratch_q [NUM_SCRATCH];
    logic [63:0] status_meta;
    logic [63:0] status_sync;
    logic [7:0]  event_reg;
    logic [7:0]  event_mask;
    logic [7:0]  wr_count;
    logic        wdog_flag;
    logic        expired_d;
    logic        ctrl_wr;
    logic [7:0]  ev_clr;
    logic [7:0]  rd_mux;
    logic [4:0]  scr_idx;
    logic        is_ctrl;

    // 0x10-0x2F packs into 0..31 using address bit 5 as the index MSB
    assign scr_idx = {address[5], address[3:0]};
    assign is_ctrl = (address[5:4] == 2'b00);

    // Low control regs are locked out while the watchdog is expired
    assign ctrl_wr = write_en && is_ctrl && !(wdog_timeout && !address[3]);
    assign ev_clr  = (write_en && address == 6'h38) ? wr_data : 8'h00;

    // Read mux: current (pre-write) register contents
    always_comb begin
        rd_mux = 8'h00;
        if (address[5:4] == 2'b00) begin
            rd_mux = ctrl_out[{address[3:0], 3'b000} +: 8];
        end else if (address[5:4] != 2'b11) begin
            rd_mux = scratch_q[scr_idx];
        end else if (!address[3]) begin
            rd_mux = status_sync[{address[2:0], 3'b000} +: 8];
        end else begin
            case (address[2:0])
                3'd0:    rd_mux = event_reg;
                3'd1:    rd_mux = {7'b0, wdog_flag};
                3'd2:    rd_mux = wr_count;
                3'd4:    rd_mux = event_mask;
                3'd7:    rd_mux = ID_VALUE;
                default: rd_mux = 8'h00;
            endcase
        end
    end

`ifdef SPI_REG_WDOG_EN
    logic [23:0] idle_cnt;
    logic [23:0] idle_cnt_d;

    // Idle counter: cleared by any access, saturates at the timeout value
    always_comb begin
        idle_cnt_d = idle_cnt;
        if (write_en || read_en) begin
            idle_cnt_d = 24'd0;
        end else if (idle_cnt != WDOG_CYCLES) begin
            idle_cnt_d = idle_cnt + 24'd1;
        end
    end

    assign expired_d = (idle_cnt_d == WDOG_CYCLES);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            idle_cnt     <= 24'd0;
            wdog_timeout <= 1'b0;
            wdog_flag    <= 1'b0;
        end else begin
            idle_cnt     <= idle_cnt_d;
            wdog_timeout <= expired_d;
            wdog_flag    <= expired_d |
                            (wdog_flag & ~(write_en && address == 6'h39 && wr_data[0]));
        end
    end
`else
    logic unused_wdog;

    assign unused_wdog  = ^WDOG_CYCLES;
    assign expired_d    = 1'b0;
    assign wdog_timeout = 1'b0;
    assign wdog_flag    = 1'b0;
`endif

    // Control registers and their write strobes
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ctrl_out     <= '0;
            write_strobe <= '0;
        end else begin
            write_strobe <= ctrl_wr ? (16'd1 << address[3:0]) : 16'd0;
            if (ctrl_wr) begin
                ctrl_out[{address[3:0], 3'b000} +: 8] <= wr_data;
            end
            // Expiry and an access never coincide, so this never masks a write
            if (expired_d) begin
                ctrl_out[63:0] <= 64'd0;
            end
        end
    end

    // Scratch RAM
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < int'(NUM_SCRATCH); i++) begin
                scratch_q[i] <= 8'h00;
            end
        end else if (write_en && address[5:4] != 2'b00 && address[5:4] != 2'b11) begin
            scratch_q[scr_idx] <= wr_data;
        end
    end

    // Status synchronizer, events, mask, counter, irq and read data
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            status_meta <= '0;
            status_sync <= '0;
            event_reg   <= 8'h00;
            event_mask  <= 8'h00;
            wr_count    <= 8'h00;
            irq         <= 1'b0;
            rd_data     <= 8'h00;
        end else begin
            status_meta <= status_in;
            status_sync <= status_meta;
            // A new event wins over a same-cycle write-1-to-clear
            event_reg   <= (event_reg & ~ev_clr) | event_in;
            if (write_en && address == 6'h3C) begin
                event_mask <= wr_data;
            end
            if (write_en) begin
                wr_count <= wr_count + 8'd1;
            end
            irq <= |(event_reg & event_mask);
            if (read_en) begin
                rd_data <= rd_mux;
            end
        end
    end

endmodule

// File: tb/tb_spi_reg_file.sv
module tb_spi_reg_file;

    logic         clock;
    logic         reset_n;
    logic [5:0]   address;
    logic         write_en;
    logic [7:0]   wr_data;
    logic         read_en;
    logic [7:0]   rd_data;
    logic [63:0]  status_in;
    logic [7:0]   event_in;
    logic [127:0] ctrl_out;
    logic [15:0]  write_strobe;
    logic         irq;
    logic         wdog_timeout;

    int tests_run;
    int tests_failed;
    logic [7:0] exp_wcnt;
    logic [7:0] rd_val;

    spi_reg_file #(
        .ID_VALUE    (8'hB5),
        .WDOG_CYCLES (24'd16)
    ) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .address      (address),
        .write_en     (write_en),
        .wr_data      (wr_data),
        .read_en      (read_en),
        .rd_data      (rd_data),
        .status_in    (status_in),
        .event_in     (event_in),
        .ctrl_out     (ctrl_out),
        .write_strobe (write_strobe),
        .irq          (irq),
        .wdog_timeout (wdog_timeout)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One write strobe spanning a single rising edge; returns on the following negedge
    task automatic do_write(input logic [5:0] a, input logic [7:0] d);
        @(negedge clock);
        address  = a;
        wr_data  = d;
        write_en = 1'b1;
        @(negedge clock);
        write_en = 1'b0;
        exp_wcnt = exp_wcnt + 8'd1;
    endtask

    task automatic do_read(input logic [5:0] a, output logic [7:0] d);
        @(negedge clock);
        address = a;
        read_en = 1'b1;
        @(negedge clock);
        read_en = 1'b0;
        d = rd_data;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        exp_wcnt     = 8'h00;
        reset_n      = 1'b0;
        address      = 6'h00;
        write_en     = 1'b0;
        wr_data      = 8'h00;
        read_en      = 1'b0;
        status_in    = 64'h0;
        event_in     = 8'h00;

        // Reset values
        repeat (3) @(negedge clock);
        check("rst_ctrl_out", ctrl_out, 128'h0);
        check("rst_rd_data", {120'h0, rd_data}, 128'h0);
        check("rst_strobe", {112'h0, write_strobe}, 128'h0);
        check("rst_irq", {127'h0, irq}, 128'h0);
        check("rst_wdog", {127'h0, wdog_timeout}, 128'h0);
        reset_n = 1'b1;

        // Control register write, strobe pulse, readback, write counter
        do_write(6'h03, 8'h5A);
        check("ctrl3_value", {120'h0, ctrl_out[31:24]}, 128'h5A);
        check("strobe_pulse", {112'h0, write_strobe}, 128'h0008);
        @(negedge clock);
        check("strobe_drop", {112'h0, write_strobe}, 128'h0);
        do_read(6'h03, rd_val);
        check("read_ctrl3", {120'h0, rd_val}, 128'h5A);
        address = 6'h3F;
        @(negedge clock);
        check("rd_hold", {120'h0, rd_data}, 128'h5A);
        do_read(6'h3A, rd_val);
        check("wcnt_1", {120'h0, rd_val}, 128'h01);

        // Read-only status byte: write ignored but counted
        status_in = 64'h0000_0000_0000_C300;
        do_write(6'h31, 8'hFF);
        do_read(6'h31, rd_val);
        check("status_1", {120'h0, rd_val}, 128'hC3);
        do_read(6'h3A, rd_val);
        check("wcnt_2", {120'h0, rd_val}, {120'h0, exp_wcnt});

        // Events, mask, irq, set-wins-over-clear
        do_write(6'h3C, 8'h04);
        @(negedge clock);
        event_in = 8'h04;
        @(negedge clock);
        event_in = 8'h00;
        @(negedge clock);
        check("irq_set", {127'h0, irq}, 128'h1);
        @(negedge clock);
        address  = 6'h38;
        wr_data  = 8'h04;
        write_en = 1'b1;
        event_in = 8'h04;
        @(negedge clock);
        write_en = 1'b0;
        event_in = 8'h00;
        exp_wcnt = exp_wcnt + 8'd1;
        do_read(6'h38, rd_val);
        check("event_set_wins", {120'h0, rd_val}, 128'h04);
        do_write(6'h38, 8'h04);
        check("irq_lag", {127'h0, irq}, 128'h1);
        @(negedge clock);
        check("irq_clear", {127'h0, irq}, 128'h0);
        do_read(6'h38, rd_val);
        check("event_cleared", {120'h0, rd_val}, 128'h00);

        // Same-cycle read and write returns the pre-write value
        @(negedge clock);
        address  = 6'h20;
        wr_data  = 8'h77;
        write_en = 1'b1;
        read_en  = 1'b1;
        @(negedge clock);
        write_en = 1'b0;
        read_en  = 1'b0;
        exp_wcnt = exp_wcnt + 8'd1;
        check("rw_prewrite", {120'h0, rd_data}, 128'h00);
        do_read(6'h20, rd_val);
        check("rw_postwrite", {120'h0, rd_val}, 128'h77);

        // 256 scratch writes wrap the counter back to its starting value
        for (int i = 0; i < 256; i++) begin
            do_write(6'h10, 8'(i));
        end
        do_read(6'h3A, rd_val);
        check("wcnt_wrap", {120'h0, rd_val}, {120'h0, exp_wcnt});
        do_read(6'h10, rd_val);
        check("scratch_last", {120'h0, rd_val}, 128'hFF);

        // ID and reserved addresses
        do_read(6'h3F, rd_val);
        check("id_value", {120'h0, rd_val}, 128'hB5);
        do_write(6'h3D, 8'hAA);
        do_read(6'h3D, rd_val);
        check("reserved_3d", {120'h0, rd_val}, 128'h00);
        do_read(6'h3B, rd_val);
        check("reserved_3b", {120'h0, rd_val}, 128'h00);

        // Watchdog: 16 idle clocks after the last access
        do_write(6'h00, 8'h7F);
        do_write(6'h08, 8'h11);
        repeat (15) @(negedge clock);
        check("wdog_before", {127'h0, wdog_timeout}, 128'h0);
        @(negedge clock);
`ifdef SPI_REG_WDOG_EN
        check("wdog_expired", {127'h0, wdog_timeout}, 128'h1);
        check("wdog_ctrl0", {120'h0, ctrl_out[7:0]}, 128'h00);
        check("wdog_ctrl8", {120'h0, ctrl_out[71:64]}, 128'h11);
        do_read(6'h39, rd_val);
        check("wdog_flag", {120'h0, rd_val}, 128'h01);
        check("wdog_dropped", {127'h0, wdog_timeout}, 128'h0);
        repeat (16) @(negedge clock);
        check("wdog_again", {127'h0, wdog_timeout}, 128'h1);
        do_write(6'h00, 8'h55);
        check("wdog_locked", {120'h0, ctrl_out[7:0]}, 128'h00);
        do_write(6'h39, 8'h01);
        do_read(6'h39, rd_val);
        check("wdog_flag_clr", {120'h0, rd_val}, 128'h00);
`else
        repeat (4) @(negedge clock);
        check("no_wdog", {127'h0, wdog_timeout}, 128'h0);
        check("no_wdog_ctrl0", {120'h0, ctrl_out[7:0]}, 128'h7F);
        do_read(6'h39, rd_val);
        check("no_wdog_39", {120'h0, rd_val}, 128'h00);
`endif

        // Asynchronous reset in the middle of an access
        do_write(6'h05, 8'h99);
        do_write(6'h3C, 8'hFF);
        @(negedge clock);
        event_in = 8'h01;
        @(negedge clock);
        event_in = 8'h00;
        address  = 6'h05;
        read_en  = 1'b1;
        #2 reset_n = 1'b0;
        #1;
        read_en = 1'b0;
        check("arst_ctrl", ctrl_out, 128'h0);
        check("arst_rd", {120'h0, rd_data}, 128'h0);
        check("arst_irq", {127'h0, irq}, 128'h0);
        check("arst_wdog", {127'h0, wdog_timeout}, 128'h0);
        @(negedge clock);
        reset_n  = 1'b1;
        exp_wcnt = 8'h00;
        do_read(6'h05, rd_val);
        check("post_rst_ctrl5", {120'h0, rd_val}, 128'h00);
        do_read(6'h3A, rd_val);
        check("post_rst_wcnt", {120'h0, rd_val}, 128'h00);
        do_read(6'h20, rd_val);
        check("post_rst_scratch", {120'h0, rd_val}, 128'h00);
        do_read(6'h38, rd_val);
        check("post_rst_event", {120'h0, rd_val}, 128'h00);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
